// File: rtl/data_sram_responder.sv
// data_sram_responder: single-port 32-bit data RAM for the core's data port.
// Byte-lane writes, registered reads and WAIT_CYCLES programmable wait states;
// data_busy is high while a delayed access is pending.
// Optional feature: define DSRAM_ERR_EN to build the BASE_ADDR range check.
// Out-of-range writes are dropped, out-of-range reads return zero, and
// data_err pulses. Without the macro, addresses alias modulo the RAM size
// and data_err is tied low.
module data_sram_responder #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_en,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_busy,
    output logic        data_err
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit          HAS_WAIT  = (WAIT_CYCLES != 0);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] req_addr_q, req_addr_d;
    logic [3:0]  req_wen_q, req_wen_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;

    logic [31:0] mem [0:DEPTH-1];

    // Access actually executed on the coming edge (live request or captured copy)
    logic                  exec_en;
    logic [29:0]           exec_addr;
    logic [3:0]            exec_wen;
    logic [31:0]           exec_wdata;
    logic [ADDR_WIDTH-1:0] exec_idx;
    logic                  in_range;

    // Pick the access source: the live port when there are no wait states,
    // otherwise the captured request on the final WAIT edge. Gating with rst_n
    // keeps the RAM from being written while reset is held.
    always_comb begin
        exec_en    = 1'b0;
        exec_addr  = data_addr[31:2];
        exec_wen   = data_wen;
        exec_wdata = data_wdata;
        if (state_q == ST_WAIT) begin
            exec_addr  = req_addr_q;
            exec_wen   = req_wen_q;
            exec_wdata = req_wdata_q;
            exec_en    = (cnt_q == 4'd1);
        end else begin
            exec_en = data_en && !HAS_WAIT;
        end
        exec_en = exec_en && rst_n;
    end

    assign exec_idx = exec_addr[ADDR_WIDTH-1:0];

`ifdef DSRAM_ERR_EN
    logic err_q;
    logic unused_addr_bits;

    assign in_range         = (exec_addr[29:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign unused_addr_bits = ^data_addr[1:0];
    assign data_err         = err_q;

    // One-cycle error pulse after an out-of-range access completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= exec_en && !in_range;
        end
    end
`else
    logic unused_addr_bits;

    assign in_range         = 1'b1;
    assign unused_addr_bits = ^{data_addr[1:0], exec_addr[29:ADDR_WIDTH], BASE_ADDR};
    assign data_err         = 1'b0;
`endif

    // State register, wait counter, request capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_wen_q   <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Next state: capture a request in IDLE when wait states are configured,
    // count down in WAIT and return to IDLE on the executing edge
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (data_en && HAS_WAIT) begin
                    req_addr_d  = data_addr[31:2];
                    req_wen_d   = data_wen;
                    req_wdata_d = data_wdata;
                    cnt_d       = WAIT_LOAD;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: busy follows the next state; read data updates only on reads
    always_comb begin
        busy_d  = (state_d == ST_WAIT);
        rdata_d = rdata_q;
        if (exec_en && (exec_wen == 4'b0000)) begin
            rdata_d = in_range ? mem[exec_idx] : '0;
        end
    end

    // RAM write port, byte-lane granular; contents are not reset
    always_ff @(posedge clk) begin
        if (exec_en && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (exec_wen[i]) begin
                    mem[exec_idx][8*i +: 8] <= exec_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_rdata = rdata_q;
    assign data_busy  = busy_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder: one instance with no wait states and one
// with three, each checked against a word-array memory model.
module tb_data_sram_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en0, en3;
    logic [3:0]  wen0, wen3;
    logic [31:0] addr0, addr3, wdata0, wdata3, rdata0, rdata3;
    logic        busy0, busy3, err0, err3;

    data_sram_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data_en(en0), .data_wen(wen0), .data_addr(addr0),
        .data_wdata(wdata0), .data_rdata(rdata0), .data_busy(busy0), .data_err(err0)
    );

    data_sram_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .data_en(en3), .data_wen(wen3), .data_addr(addr3),
        .data_wdata(wdata3), .data_rdata(rdata3), .data_busy(busy3), .data_err(err3)
    );

`ifdef DSRAM_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m0 [4096];
    logic [31:0] m3 [4096];
    logic [31:0] exp_rd0, exp_rd3;
    logic        exp_err0, exp_err3;

    function automatic bit model_in_range(input logic [31:0] a);
        return !ERR_BUILD || (a[31:14] == 18'h0);
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] wen);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (wen[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // One access on the zero-wait instance, then advance the model
    task automatic acc0(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        logic [11:0] idx;
        @(negedge clk);
        en0 = 1'b1; wen0 = wen; addr0 = addr; wdata0 = wdata;
        @(posedge clk);
        #1;
        en0 = 1'b0;
        idx = addr[13:2];
        if (!model_in_range(addr)) begin
            exp_err0 = 1'b1;
            if (wen == 4'h0) exp_rd0 = 32'h0;
        end else begin
            exp_err0 = 1'b0;
            if (wen == 4'h0) exp_rd0 = m0[idx];
            else m0[idx] = lane_merge(m0[idx], wdata, wen);
        end
    endtask

    // One access on the wait-state instance; garbage is driven while busy and
    // the number of busy cycles seen is returned (bounded)
    task automatic acc3(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                        output int busy_n);
        logic [11:0] idx;
        @(negedge clk);
        en3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wdata;
        @(posedge clk);
        #1;
        busy_n = 0;
        while (busy3 === 1'b1 && busy_n < 20) begin
            busy_n++;
            @(negedge clk);
            addr3 = $urandom; wen3 = 4'($urandom); wdata3 = $urandom;
            @(posedge clk);
            #1;
        end
        en3 = 1'b0;
        idx = addr[13:2];
        if (!model_in_range(addr)) begin
            exp_err3 = 1'b1;
            if (wen == 4'h0) exp_rd3 = 32'h0;
        end else begin
            exp_err3 = 1'b0;
            if (wen == 4'h0) exp_rd3 = m3[idx];
            else m3[idx] = lane_merge(m3[idx], wdata, wen);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en0 = 0; wen0 = 0; addr0 = 0; wdata0 = 0;
        en3 = 0; wen3 = 0; addr3 = 0; wdata3 = 0;
        #1;
        vectors++;
        if ({rdata0, busy0, err0} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_dut0: got rdata=%h busy=%b err=%b, want 0/0/0", rdata0, busy0, err0);
        end
        vectors++;
        if ({rdata3, busy3, err3} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_dut3: got rdata=%h busy=%b err=%b, want 0/0/0", rdata3, busy3, err3);
        end
        exp_rd0 = 0; exp_rd3 = 0; exp_err0 = 0; exp_err3 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_byte_lanes();
        acc0(4'hF, 32'h10, 32'h1122_3344);
        vectors++;
        if (busy0 !== 1'b0) begin miscompares++; $display("FAIL lane_busy_w1: got %b want 0", busy0); end
        acc0(4'b1001, 32'h10, 32'hAA55_66BB);
        vectors++;
        if (busy0 !== 1'b0) begin miscompares++; $display("FAIL lane_busy_w2: got %b want 0", busy0); end
        acc0(4'h0, 32'h10, 32'h0);
        vectors++;
        if (rdata0 !== 32'hAA22_33BB) begin
            miscompares++; $display("FAIL lane_read: got %h want %h", rdata0, 32'hAA22_33BB);
        end
        vectors++;
        if (busy0 !== 1'b0) begin miscompares++; $display("FAIL lane_busy_r: got %b want 0", busy0); end
    endtask

    task automatic test_back_to_back();
        int n;
        acc0(4'hF, 32'h24, 32'h1234_5678);
        acc0(4'hF, 32'h20, 32'hCAFE_F00D);
        acc0(4'h0, 32'h20, 32'h0);
        vectors++;
        if (rdata0 !== 32'hCAFE_F00D) begin
            miscompares++; $display("FAIL b2b_raw: got %h want %h", rdata0, 32'hCAFE_F00D);
        end
        acc0(4'h0, 32'h24, 32'h0);
        vectors++;
        if (rdata0 !== 32'h1234_5678) begin
            miscompares++; $display("FAIL b2b_neighbour: got %h want %h", rdata0, 32'h1234_5678);
        end
        acc3(4'hF, 32'h20, 32'hCAFE_F00D, n);
        vectors++;
        if (n != 3) begin miscompares++; $display("FAIL b2b_wr_busy3: got %0d cycles want 3", n); end
    endtask

    task automatic test_wait_states();
        int n;
        acc3(4'h0, 32'h20, 32'h0, n);
        vectors++;
        if (n != 3) begin miscompares++; $display("FAIL ws_busy_cycles: got %0d want 3", n); end
        vectors++;
        if (rdata3 !== 32'hCAFE_F00D) begin
            miscompares++; $display("FAIL ws_read: got %h want %h", rdata3, 32'hCAFE_F00D);
        end
        @(negedge clk);
        vectors++;
        if (rdata3 !== 32'hCAFE_F00D || busy3 !== 1'b0) begin
            miscompares++; $display("FAIL ws_hold: got rdata=%h busy=%b want %h/0", rdata3, busy3, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_reset_mid_access();
        int n;
        acc3(4'hF, 32'h30, 32'h0, n);
        acc3(4'h0, 32'h20, 32'h0, n);
        @(negedge clk);
        en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h30; wdata3 = 32'h5555_5555;
        @(posedge clk);
        #1;
        en3 = 1'b0;
        vectors++;
        if (busy3 !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy: got %b want 1", busy3); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rdata3, busy3, err3} !== 34'h0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got rdata=%h busy=%b err=%b want 0/0/0", rdata3, busy3, err3);
        end
        exp_rd0 = 0; exp_rd3 = 0; exp_err0 = 0; exp_err3 = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc3(4'h0, 32'h30, 32'h0, n);
        vectors++;
        if (rdata3 !== 32'h0 || n != 3) begin
            miscompares++; $display("FAIL rst_discard: got rdata=%h busy=%0d want 0/3", rdata3, n);
        end
    endtask

    task automatic test_out_of_range();
        acc0(4'hF, 32'h10, 32'h1357_9BDF);
        acc0(4'hF, 32'h0000_4010, 32'hDEAD_BEEF);
        vectors++;
        if (err0 !== (ERR_BUILD ? 1'b1 : 1'b0)) begin
            miscompares++; $display("FAIL oor_err_pulse: got %b want %b", err0, ERR_BUILD);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (err0 !== 1'b0) begin miscompares++; $display("FAIL oor_err_clear: got %b want 0", err0); end
        acc0(4'h0, 32'h10, 32'h0);
        vectors++;
        if (rdata0 !== (ERR_BUILD ? 32'h1357_9BDF : 32'hDEAD_BEEF)) begin
            miscompares++;
            $display("FAIL oor_target: got %h want %h", rdata0, ERR_BUILD ? 32'h1357_9BDF : 32'hDEAD_BEEF);
        end
        acc0(4'h0, 32'h0000_4010, 32'h0);
        vectors++;
        if (rdata0 !== exp_rd0 || err0 !== exp_err0) begin
            miscompares++;
            $display("FAIL oor_read: got rdata=%h err=%b want %h/%b", rdata0, err0, exp_rd0, exp_err0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {18'h0, 8'h0, 4'($urandom), 2'($urandom)};
        if ($urandom_range(0, 3) == 0) a[31:14] = 18'($urandom);
        return a;
    endfunction

    task automatic test_random();
        logic [3:0]  w;
        logic [31:0] a;
        int n;
        for (int i = 0; i < 16; i++) begin
            acc0(4'hF, 32'(i * 4), $urandom);
            acc3(4'hF, 32'(i * 4), $urandom, n);
        end
        for (int i = 0; i < 300; i++) begin
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            a = rand_addr();
            acc0(w, a, $urandom);
            vectors++;
            if (rdata0 !== exp_rd0 || err0 !== exp_err0 || busy0 !== 1'b0) begin
                miscompares++;
                $display("FAIL rand0[%0d]: addr=%h wen=%h got rdata=%h err=%b busy=%b want %h/%b/0",
                         i, a, w, rdata0, err0, busy0, exp_rd0, exp_err0);
            end
        end
        for (int i = 0; i < 40; i++) begin
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            a = rand_addr();
            acc3(w, a, $urandom, n);
            vectors++;
            if (rdata3 !== exp_rd3 || err3 !== exp_err3 || n != 3) begin
                miscompares++;
                $display("FAIL rand3[%0d]: addr=%h wen=%h got rdata=%h err=%b busy=%0d want %h/%b/3",
                         i, a, w, rdata3, err3, n, exp_rd3, exp_err3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_access();
        test_out_of_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
